// File: rtl/matrix_dispatcher_pkg.sv
// Shared definitions for the matrix dispatcher and column processor: FSM encoding and bus packing.
package matrix_dispatcher_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_ACK   = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // LSB of element k on a bus packing cells of cell_width bits, element 0 at the bottom.
    function automatic int elem_lsb(input int k, input int cell_width);
        return k * cell_width;
    endfunction

endpackage

// File: rtl/matrix_buffer.sv
// size*size cell register file, one write port, all cells exposed flat; write visible next cycle.
// No backpressure: a write strobe is always accepted; out-of-range addresses are dropped.
module matrix_buffer
    import matrix_dispatcher_pkg::*;
#(
    parameter int size       = 2,
    parameter int cell_width = 32,
    localparam int aw        = $clog2(size * size)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [aw-1:0]                     wr_addr,
    input  logic [cell_width-1:0]             wr_data,
    output logic [size*size*cell_width-1:0]   cells
);

    localparam logic [aw:0] n_cells = (aw + 1)'(size * size);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells <= '0;
        end else if (wr_en && ({1'b0, wr_addr} < n_cells)) begin
            cells[elem_lsb(int'(wr_addr), cell_width) +: cell_width] <= wr_data;
        end
    end

endmodule

// File: rtl/matrix_dispatcher.sv
// Walks every C[i][j], presenting row i of A / column j of B over a four-phase ready/ack handshake.
// 3 cycles per cell with a zero-wait responder; stalls indefinitely on either handshake phase.
module matrix_dispatcher
    import matrix_dispatcher_pkg::*;
#(
    parameter int size       = 2,
    parameter int cell_width = 32,
    localparam int aw        = $clog2(size * size),
    localparam int iw        = (size > 1) ? $clog2(size) : 1
) (
    input  logic                         in_clk,
    input  logic                         in_reset,
    input  logic                         in_wr_en,
    input  logic                         in_wr_sel,
    input  logic [aw-1:0]                in_wr_addr,
    input  logic [cell_width-1:0]        in_wr_data,
    input  logic                         in_start,
    input  logic [aw-1:0]                in_rd_addr,
    output logic [cell_width-1:0]        out_rd_data,
    output logic                         out_busy,
    output logic                         out_done,
    output logic [size*cell_width-1:0]   out_row_a,
    output logic [size*cell_width-1:0]   out_col_b,
    output logic                         out_cp_ready,
    output logic                         out_cp_ack,
    input  logic                         in_cp_ready,
    input  logic [cell_width-1:0]        in_cp_cell
);

    localparam logic [iw-1:0] last   = iw'(size - 1);
    localparam logic [aw:0]  n_cells = (aw + 1)'(size * size);

    logic [2:0]                       state;
    logic [iw-1:0]                    i;
    logic [iw-1:0]                    j;
    logic [aw-1:0]                    cur_addr;
    logic                             a_wr_en;
    logic                             b_wr_en;
    logic                             c_wr_en;
    logic [size*size*cell_width-1:0]  a_cells;
    logic [size*size*cell_width-1:0]  b_cells;
    logic [size*size*cell_width-1:0]  c_cells;

    // Host writes only land while idle; a running job sees frozen operands.
    assign a_wr_en  = (state == ST_IDLE) && in_wr_en && !in_wr_sel;
    assign b_wr_en  = (state == ST_IDLE) && in_wr_en &&  in_wr_sel;
    assign c_wr_en  = (state == ST_ISSUE) && in_cp_ready;
    assign cur_addr = aw'(int'(i) * size + int'(j));

    matrix_buffer #(.size(size), .cell_width(cell_width)) u_buf_a (
        .clk     (in_clk),
        .rst_n   (in_reset),
        .wr_en   (a_wr_en),
        .wr_addr (in_wr_addr),
        .wr_data (in_wr_data),
        .cells   (a_cells)
    );

    matrix_buffer #(.size(size), .cell_width(cell_width)) u_buf_b (
        .clk     (in_clk),
        .rst_n   (in_reset),
        .wr_en   (b_wr_en),
        .wr_addr (in_wr_addr),
        .wr_data (in_wr_data),
        .cells   (b_cells)
    );

    matrix_buffer #(.size(size), .cell_width(cell_width)) u_buf_c (
        .clk     (in_clk),
        .rst_n   (in_reset),
        .wr_en   (c_wr_en),
        .wr_addr (cur_addr),
        .wr_data (in_cp_cell),
        .cells   (c_cells)
    );

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state        <= ST_IDLE;
            i            <= '0;
            j            <= '0;
            out_cp_ready <= 1'b0;
            out_cp_ack   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        i            <= '0;
                        j            <= '0;
                        out_cp_ready <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (in_cp_ready) begin
                        out_cp_ready <= 1'b0;
                        out_cp_ack   <= 1'b1;
                        state        <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!in_cp_ready) begin
                        out_cp_ack <= 1'b0;
                        state      <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (i == last && j == last) begin
                        state <= ST_DONE;
                    end else begin
                        if (j == last) begin
                            j <= '0;
                            i <= i + iw'(1);
                        end else begin
                            j <= j + iw'(1);
                        end
                        out_cp_ready <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_busy = (state != ST_IDLE);
    assign out_done = (state == ST_DONE);

    // Operand buses follow the counters, which only move in NEXT.
    always_comb begin
        out_row_a = '0;
        out_col_b = '0;
        for (int k = 0; k < size; k++) begin
            out_row_a[elem_lsb(k, cell_width) +: cell_width] =
                a_cells[elem_lsb(int'(i) * size + k, cell_width) +: cell_width];
            out_col_b[elem_lsb(k, cell_width) +: cell_width] =
                b_cells[elem_lsb(k * size + int'(j), cell_width) +: cell_width];
        end
    end

    always_comb begin
        out_rd_data = '0;
        if ({1'b0, in_rd_addr} < n_cells) begin
            out_rd_data = c_cells[elem_lsb(int'(in_rd_addr), cell_width) +: cell_width];
        end
    end

endmodule

// File: tb/tb_matrix_dispatcher.sv
// Directed bench for matrix_dispatcher with a mock column processor and a C-value scoreboard.
module tb_matrix_dispatcher;

    localparam int size = 2;
    localparam int cw   = 32;
    localparam int aw   = 2;
    localparam int nc   = size * size;

    logic               in_clk;
    logic               in_reset;
    logic               in_wr_en;
    logic               in_wr_sel;
    logic [aw-1:0]      in_wr_addr;
    logic [cw-1:0]      in_wr_data;
    logic               in_start;
    logic [aw-1:0]      in_rd_addr;
    logic [cw-1:0]      out_rd_data;
    logic               out_busy;
    logic               out_done;
    logic [size*cw-1:0] out_row_a;
    logic [size*cw-1:0] out_col_b;
    logic               out_cp_ready;
    logic               out_cp_ack;
    logic               in_cp_ready;
    logic [cw-1:0]      in_cp_cell;

    matrix_dispatcher #(.size(size), .cell_width(cw)) dut (
        .in_clk       (in_clk),
        .in_reset     (in_reset),
        .in_wr_en     (in_wr_en),
        .in_wr_sel    (in_wr_sel),
        .in_wr_addr   (in_wr_addr),
        .in_wr_data   (in_wr_data),
        .in_start     (in_start),
        .in_rd_addr   (in_rd_addr),
        .out_rd_data  (out_rd_data),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_row_a    (out_row_a),
        .out_col_b    (out_col_b),
        .out_cp_ready (out_cp_ready),
        .out_cp_ack   (out_cp_ack),
        .in_cp_ready  (in_cp_ready),
        .in_cp_cell   (in_cp_cell)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] a_m [nc];
    logic [31:0] b_m [nc];
    logic [31:0] exp_q [$];
    int          resp_idx   = 0;
    int          stall_cell = -1;
    int          stall_len  = 0;
    int          stall_cnt  = 0;
    int          hold_cell  = -1;
    int          hold_len   = 0;
    int          hold_cnt   = 0;
    int          done_cnt   = 0;
    logic [63:0] stall_row;
    logic [63:0] stall_col;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] exp_row(input int idx);
        int r = idx / size;
        return {a_m[r*size+1], a_m[r*size]};
    endfunction

    function automatic logic [63:0] exp_col(input int idx);
        int c = idx % size;
        return {b_m[size+c], b_m[c]};
    endfunction

    // Mock column processor: answers ready one cycle after it sees the request, with optional stalls.
    always @(posedge in_clk) begin
        #1;
        if (!in_reset) begin
            in_cp_ready = 1'b0;
            resp_idx    = 0;
            stall_cnt   = 0;
            hold_cnt    = 0;
        end else if (out_done) begin
            resp_idx  = 0;
            stall_cnt = 0;
            hold_cnt  = 0;
        end else if (out_cp_ready && !in_cp_ready) begin
            if (resp_idx == stall_cell && stall_cnt < stall_len) begin
                if (stall_cnt == 0) begin
                    stall_row = out_row_a;
                    stall_col = out_col_b;
                end else begin
                    chk("stall_row_stable", out_row_a, stall_row);
                    chk("stall_col_stable", out_col_b, stall_col);
                    chk("stall_ack_low", 64'(out_cp_ack), 64'd0);
                end
                stall_cnt++;
            end else begin
                chk("row_a", out_row_a, exp_row(resp_idx));
                chk("col_b", out_col_b, exp_col(resp_idx));
                in_cp_ready = 1'b1;
                in_cp_cell  = 32'h40B33333 + 32'(resp_idx);
                exp_q.push_back(in_cp_cell);
            end
        end else if (out_cp_ack && in_cp_ready) begin
            if (resp_idx == hold_cell && hold_cnt < hold_len) begin
                chk("hold_ack_high", 64'(out_cp_ack), 64'd1);
                chk("hold_ready_low", 64'(out_cp_ready), 64'd0);
                in_cp_cell = 32'hDEADBEEF;
                hold_cnt++;
            end else begin
                in_cp_ready = 1'b0;
                resp_idx++;
            end
        end
    end

    always @(negedge in_clk) if (out_done) done_cnt++;

    task automatic write_cell(input logic sel, input int addr, input logic [31:0] data);
        @(negedge in_clk);
        in_wr_en   = 1'b1;
        in_wr_sel  = sel;
        in_wr_addr = aw'(addr);
        in_wr_data = data;
        @(posedge in_clk);
        #1 in_wr_en = 1'b0;
    endtask

    task automatic load_model;
        for (int k = 0; k < nc; k++) write_cell(1'b0, k, a_m[k]);
        for (int k = 0; k < nc; k++) write_cell(1'b1, k, b_m[k]);
    endtask

    task automatic start_job;
        @(negedge in_clk);
        in_start = 1'b1;
        @(posedge in_clk);
        #1 in_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && !out_done; k++) @(negedge in_clk);
        chk(tag, 64'(out_done), 64'd1);
        @(negedge in_clk);
    endtask

    task automatic readback(input string tag);
        chk({tag, "_q_size"}, 64'(exp_q.size()), 64'(nc));
        for (int k = 0; k < nc && exp_q.size() > 0; k++) begin
            in_rd_addr = aw'(k);
            #1 chk(tag, 64'(out_rd_data), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  64'(out_busy), 64'd0);
        chk({tag, "_done"},  64'(out_done), 64'd0);
        chk({tag, "_ready"}, 64'(out_cp_ready), 64'd0);
        chk({tag, "_ack"},   64'(out_cp_ack), 64'd0);
        chk({tag, "_row"},   out_row_a, 64'd0);
        chk({tag, "_col"},   out_col_b, 64'd0);
        for (int k = 0; k < nc; k++) begin
            in_rd_addr = aw'(k);
            #1 chk({tag, "_c"}, 64'(out_rd_data), 64'd0);
        end
    endtask

    int done_before;

    initial begin
        in_reset = 1'b0; in_wr_en = 1'b0; in_wr_sel = 1'b0; in_wr_addr = '0;
        in_wr_data = '0; in_start = 1'b0; in_rd_addr = '0;
        in_cp_ready = 1'b0; in_cp_cell = '0;

        // Reset state
        repeat (3) @(posedge in_clk);
        #1 check_all_zero("reset");
        @(negedge in_clk) in_reset = 1'b1;
        repeat (4) @(posedge in_clk);
        #1 chk("idle_busy", 64'(out_busy), 64'd0);
        chk("idle_ready", 64'(out_cp_ready), 64'd0);

        // Basic job with exact latency
        a_m = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        b_m = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
        load_model();
        start_job();
        chk("start_busy", 64'(out_busy), 64'd1);
        chk("start_ready", 64'(out_cp_ready), 64'd1);
        chk("cell00_row", out_row_a, 64'h400000003F800000);
        chk("cell00_col", out_col_b, 64'h000000003F800000);
        repeat (11) @(posedge in_clk);
        #1 chk("done_not_early", 64'(out_done), 64'd0);
        @(posedge in_clk);
        #1 chk("done_at_12", 64'(out_done), 64'd1);
        chk("busy_with_done", 64'(out_busy), 64'd1);
        @(posedge in_clk);
        #1 chk("done_falls", 64'(out_done), 64'd0);
        chk("busy_falls", 64'(out_busy), 64'd0);
        readback("c_basic");

        // Ready stall on (0,1), ack stall on (1,0), busy guards during the ready stall
        stall_cell = 1; stall_len = 7;
        hold_cell  = 2; hold_len  = 5;
        done_before = done_cnt;
        start_job();
        for (int k = 0; k < 50 && stall_cnt < 3; k++) @(negedge in_clk);
        chk("stall_reached", 64'(stall_cnt >= 3), 64'd1);
        @(negedge in_clk);
        in_start = 1'b1; in_wr_en = 1'b1; in_wr_sel = 1'b0;
        in_wr_addr = '0; in_wr_data = 32'h41200000;
        @(posedge in_clk);
        #1 in_start = 1'b0; in_wr_en = 1'b0;
        wait_done("stall_job_done", 200);
        repeat (8) @(negedge in_clk);
        chk("one_done_pulse", 64'(done_cnt - done_before), 64'd1);
        chk("stall_len_seen", 64'(stall_cnt == 0), 64'd1);
        readback("c_stall");
        stall_cell = -1; hold_cell = -1;

        // Guarded write must not have reached A: next job still presents the original row 0
        start_job();
        chk("a0_unchanged", out_row_a, 64'h400000003F800000);

        // Reset during ACK of cell (1,0)
        for (int k = 0; k < 50 && !(resp_idx == 2 && out_cp_ack); k++) @(negedge in_clk);
        chk("reached_ack_10", 64'(resp_idx == 2 && out_cp_ack), 64'd1);
        in_reset = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge in_clk);
        in_reset = 1'b1;

        // Fresh load after reset
        for (int k = 0; k < nc; k++) begin
            a_m[k] = $urandom;
            b_m[k] = $urandom;
        end
        load_model();
        start_job();
        wait_done("fresh_job_done", 100);
        readback("c_fresh");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
